cache_mem_ctrl: RTL and testbench

- Line-refill/write-back engine between the data cache miss port and the word-wide synchronous data RAM.
- Takes one line-granular request from the cache and converts it into LINE_WORDS consecutive single-word RAM accesses.
- For reads, gathers the returned words into a line and hands back one response pulse.
- Sits directly downstream of the D-cache, replacing the ad-hoc adapter in the memory path.

---
 rtl/cache_mem_pkg.sv | 18 +
 rtl/cache_mem_rd_pipe.sv | 35 +++
 rtl/cache_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared state encoding, line geometry and line type for the cache line
// refill/write-back engine (cache_mem_ctrl).
package cache_mem_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS) + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [LINE_WORDS-1:0][WORD_BITS-1:0] line_t;

endpackage

// File: rtl/cache_mem_rd_pipe.sv
// RAM_LAT-deep valid/index shift pipe: an index pushed with the read address
// emerges exactly when the RAM returns that word.
module cache_mem_rd_pipe #(
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RAM_LAT-1:0] vld_q;
  logic [IDX_W-1:0]   idx_q [RAM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RAM_LAT-1];
  assign out_idx   = idx_q[RAM_LAT-1];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Line refill/write-back engine between the D-cache miss port and a word-wide
// synchronous RAM. Define CACHE_MEM_CTRL_PERF_EN to add line-completion counters.
module cache_mem_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic                         req_wen,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W*LINE_WORDS-1:0] req_data,
  output logic                         resp_valid,
  output logic [DATA_W*LINE_WORDS-1:0] resp_data,
  output logic                         busy,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata
`ifdef CACHE_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]                  perf_rd_lines,
  output logic [31:0]                  perf_wr_lines
`endif
);

  import cache_mem_pkg::*;

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned LOFF_W = BEAT_W + 2;
  localparam int unsigned TAG_W  = ADDR_W - LOFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t                                state;
  logic [TAG_W-1:0]                      tag_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0]     line_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0]     line_cap;
  logic [BEAT_W-1:0]                     beat_q;
  logic [BEAT_W-1:0]                     beat_nx;
  logic                                  iss_q;
  logic                                  issue_rd;
  logic                                  cap_valid;
  logic [BEAT_W-1:0]                     cap_idx;
  logic                                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[LOFF_W-1:0];
  assign beat_nx  = beat_q + 1'b1;
  assign issue_rd = (state == RD) && iss_q;

  // Beat index replaces the offset bits, so a line never carries into the next one.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [BEAT_W-1:0] beat);
    return {tag, beat, 2'b00};
  endfunction

  cache_mem_rd_pipe #(
    .RAM_LAT (RAM_LAT),
    .IDX_W   (BEAT_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_rd),
    .in_idx    (beat_q),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  always_comb begin
    line_cap          = line_q;
    line_cap[cap_idx] = ram_rdata;
  end

  // Issue registers are loaded one beat ahead so each beat appears the cycle it is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tag_q      <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      iss_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tag_q    <= req_addr[ADDR_W-1:LOFF_W];
            line_q   <= req_data;
            beat_q   <= '0;
            busy     <= 1'b1;
            ram_addr <= beat_addr(req_addr[ADDR_W-1:LOFF_W], '0);
            if (req_wen) begin
              state     <= WR;
              ram_we    <= 1'b1;
              ram_wdata <= req_data[DATA_W-1:0];
            end else begin
              state <= RD;
              iss_q <= 1'b1;
            end
          end
        end
        WR: begin
          beat_q <= beat_nx;
          if (beat_q == LAST_BEAT) begin
            ram_we     <= 1'b0;
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            ram_addr  <= beat_addr(tag_q, beat_nx);
            ram_wdata <= line_q[beat_nx];
          end
        end
        RD: begin
          if (iss_q) begin
            beat_q <= beat_nx;
            if (beat_q == LAST_BEAT) iss_q <= 1'b0;
            else                     ram_addr <= beat_addr(tag_q, beat_nx);
          end
          if (cap_valid) begin
            line_q <= line_cap;
            if (cap_idx == LAST_BEAT) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= line_cap;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_MEM_CTRL_PERF_EN
  logic        wen_q;
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      if (state == IDLE && req_valid) wen_q <= req_wen;
      if (resp_valid && !wen_q && perf_rd_q != '1) perf_rd_q <= perf_rd_q + 1'b1;
      if (resp_valid &&  wen_q && perf_wr_q != '1) perf_wr_q <= perf_wr_q + 1'b1;
    end
  end

  assign perf_rd_lines = perf_rd_q;
  assign perf_wr_lines = perf_wr_q;
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: two lanes (RAM_LAT=1 and RAM_LAT=3), each with a
// behavioural RAM and a transaction-level model checked every cycle.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;

  localparam int unsigned LW        = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned LINE_BITS = LW * DW;
  typedef logic [LINE_BITS-1:0] tline_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  tline_t      req_data  [2];
  logic        resp_valid[2];
  tline_t      resp_data [2];
  logic        busy      [2];
  logic        ram_we    [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];
`ifdef CACHE_MEM_CTRL_PERF_EN
  logic [31:0] perf_rd   [2];
  logic [31:0] perf_wr   [2];
`endif

  logic [31:0] ram_mem [logic [32:0]];
  logic [31:0] mdl_mem [logic [32:0]];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input tline_t act, input tline_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [32:0] key);
    return ram_mem.exists(key) ? ram_mem[key] : 32'h0;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [32:0] key);
    return mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gl
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    localparam bit          LN  = (g != 0);

    cache_mem_ctrl #(
      .ADDR_W     (32),
      .DATA_W     (DW),
      .LINE_WORDS (LW),
      .RAM_LAT    (LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_wen    (req_wen[g]),
      .req_addr   (req_addr[g]),
      .req_data   (req_data[g]),
      .resp_valid (resp_valid[g]),
      .resp_data  (resp_data[g]),
      .busy       (busy[g]),
      .ram_we     (ram_we[g]),
      .ram_addr   (ram_addr[g]),
      .ram_wdata  (ram_wdata[g]),
      .ram_rdata  (ram_rdata[g])
`ifdef CACHE_MEM_CTRL_PERF_EN
      ,
      .perf_rd_lines (perf_rd[g]),
      .perf_wr_lines (perf_wr[g])
`endif
    );

    // Behavioural synchronous RAM: read data appears LAT cycles after the address.
    logic [31:0] rq [LAT];
    always @(posedge clk) begin
      rq[0] <= ram_rd({LN, ram_addr[g]});
      for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    always @(negedge clk) if (ram_we[g] === 1'b1) ram_mem[{LN, ram_addr[g]}] = ram_wdata[g];
    assign ram_rdata[g] = rq[LAT-1];

    // Transaction model: k counts cycles since acceptance, 0 when idle.
    int          k = 0;
    bit          m_wen = 1'b0;
    logic [31:0] m_base = '0;
    tline_t      m_line = '0;
    tline_t      e_resp = '0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wd = '0;

    always @(negedge clk) begin
      int   total;
      logic e_we, e_rv, e_busy;
      if (rst) begin
        k = 0; m_wen = 1'b0; e_addr = '0; e_wd = '0; e_resp = '0;
      end
      total  = m_wen ? LW + 1 : LW + LAT + 1;
      e_busy = (k != 0);
      e_rv   = (k == total);
      e_we   = m_wen && k >= 1 && k <= LW;
      if (k >= 1 && k <= LW) begin
        e_addr = m_base + 32'(4 * (k - 1));
        if (m_wen) begin
          e_wd = m_line[(k-1)*DW +: DW];
          mdl_mem[{LN, e_addr}] = e_wd;
        end
      end
      if (e_rv && !m_wen)
        for (int i = 0; i < LW; i++) e_resp[i*DW +: DW] = mdl_rd({LN, m_base + 32'(4 * i)});
      check($sformatf("L%0d.resp_valid", g), tline_t'(resp_valid[g]), tline_t'(e_rv));
      check($sformatf("L%0d.busy", g),       tline_t'(busy[g]),       tline_t'(e_busy));
      check($sformatf("L%0d.ram_we", g),     tline_t'(ram_we[g]),     tline_t'(e_we));
      check($sformatf("L%0d.ram_addr", g),   tline_t'(ram_addr[g]),   tline_t'(e_addr));
      check($sformatf("L%0d.ram_wdata", g),  tline_t'(ram_wdata[g]),  tline_t'(e_wd));
      check($sformatf("L%0d.resp_data", g),  resp_data[g],            e_resp);
      if (!rst) begin
        if (k == total)    k = 0;
        else if (k != 0)   k++;
        else if (req_valid[g]) begin
          k      = 1;
          m_wen  = req_wen[g];
          m_base = req_addr[g] & ~32'(LW * 4 - 1);
          m_line = req_data[g];
        end
      end
    end
  end

  logic [31:0] rec_addr [LW+1];
  logic [31:0] rec_wd   [LW+1];
  logic        rec_we   [LW+1];
  logic        rec_busy;
  tline_t      rec_resp;
  int          rec_lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an idle cycle; returns in the resp_valid cycle with req_valid still high.
  task automatic do_req(input int ln, input bit wen, input logic [31:0] addr, input tline_t data);
    req_valid[ln] = 1'b1;
    req_wen[ln]   = wen;
    req_addr[ln]  = addr;
    req_data[ln]  = data;
    rec_lat  = -1;
    rec_busy = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      rec_busy &= busy[ln];
      if (n <= LW) begin
        rec_addr[n] = ram_addr[ln];
        rec_we[n]   = ram_we[ln];
        rec_wd[n]   = ram_wdata[ln];
      end
      if (resp_valid[ln]) begin
        rec_lat  = n;
        rec_resp = resp_data[ln];
        break;
      end
    end
    if (rec_lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: lane %0d got no resp_valid within 40 cycles", ln);
    end
  endtask

  task automatic drop(input int ln);
    step();
    req_valid[ln] = 1'b0;
  endtask

  localparam tline_t REFILL_LINE = 128'h000000A3_000000A2_000000A1_000000A0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int resp_seen;
    rst = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      req_valid[ln] = 1'b0; req_wen[ln] = 1'b0; req_addr[ln] = '0; req_data[ln] = '0;
      for (int i = 0; i < LW; i++) begin
        ram_mem[{ln[0], 32'h200 + 32'(4 * i)}] = 32'hA0 + 32'(i);
        mdl_mem[{ln[0], 32'h200 + 32'(4 * i)}] = 32'hA0 + 32'(i);
      end
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    // Write-back of a line at 0x100
    do_req(0, 1'b1, 32'h0000_0104, 128'h00000044_00000033_00000022_00000011);
    check("wb_latency", tline_t'(rec_lat), 5);
    check("wb_busy", tline_t'(rec_busy), 1);
    for (int i = 1; i <= LW; i++) begin
      check("wb_addr", tline_t'(rec_addr[i]), tline_t'(32'h100 + 32'(4 * (i - 1))));
      check("wb_we", tline_t'(rec_we[i]), 1);
      check("wb_wdata", tline_t'(rec_wd[i]), tline_t'(32'h11 * i));
    end
    drop(0);

    // Refill, both RAM latencies
    do_req(0, 1'b0, 32'h0000_020C, '0);
    check("rf_latency_l1", tline_t'(rec_lat), 6);
    check("rf_data_l1", rec_resp, REFILL_LINE);
    drop(0);
    do_req(1, 1'b0, 32'h0000_020C, '0);
    check("rf_latency_l3", tline_t'(rec_lat), 8);
    check("rf_data_l3", rec_resp, REFILL_LINE);
    drop(1);

    // Back-to-back write then read of the same line
    do_req(0, 1'b1, 32'h0000_0300, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    step();
    do_req(0, 1'b0, 32'h0000_0308, '0);
    check("b2b_latency", tline_t'(rec_lat), 6);
    check("b2b_data", rec_resp, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    drop(0);
    step();
    step();
    check("b2b_no_dup", tline_t'(busy[0]), 0);

    // Line at the top of the address space
    do_req(0, 1'b0, 32'hFFFF_FFF8, '0);
    for (int i = 1; i <= LW; i++) begin
      check("wrap_addr", tline_t'(rec_addr[i]), tline_t'(32'hFFFF_FFF0 + 32'(4 * (i - 1))));
      check("wrap_we", tline_t'(rec_we[i]), 0);
    end
    check("wrap_latency", tline_t'(rec_lat), 6);
    drop(0);

    // Reset during read beat 2
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h200;
    step();
    step();
    step();
    check("rst_beat2_addr", tline_t'(ram_addr[0]), 32'h208);
    rst = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    check("rst_busy", tline_t'(busy[0]), 0);
    check("rst_addr", tline_t'(ram_addr[0]), 0);
    check("rst_resp_data", resp_data[0], 0);
    step();
    rst = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_valid[0]) resp_seen++;
    end
    check("rst_no_resp", tline_t'(resp_seen), 0);
    do_req(0, 1'b0, 32'h0000_020C, '0);
    check("post_rst_latency", tline_t'(rec_lat), 6);
    check("post_rst_data", rec_resp, REFILL_LINE);
    drop(0);

`ifdef CACHE_MEM_CTRL_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b0, 32'h200, '0);
      drop(0);
    end
    for (int i = 0; i < 2; i++) begin
      do_req(0, 1'b1, 32'h400 + 32'(16 * i), 128'h1);
      drop(0);
    end
    step();
    check("perf_rd", tline_t'(perf_rd[0]), 3);
    check("perf_wr", tline_t'(perf_wr[0]), 2);
    force gl[0].u_dut.perf_rd_q = 32'hFFFF_FFFF;
    step();
    release gl[0].u_dut.perf_rd_q;
    do_req(0, 1'b0, 32'h200, '0);
    drop(0);
    step();
    check("perf_rd_sat", tline_t'(perf_rd[0]), 32'hFFFF_FFFF);
    check("perf_wr_hold", tline_t'(perf_wr[0]), 2);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
